// File: rtl/viterbi_pkg.sv
// Shared types and constants for the K=3 Viterbi decoder blocks.
package viterbi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACS  = 2'd1,
    TB   = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int K          = 3;
  localparam int NUM_STATES = 1 << (K - 1);
  localparam int METRIC_W   = 8;

  // Path metrics the ACS loads on acs_init: state 0 starts best, all others worst.
  localparam logic [METRIC_W-1:0] INIT_METRIC_ZERO = '0;
  localparam logic [METRIC_W-1:0] INIT_METRIC_MAX  = '1;

  function automatic logic [METRIC_W-1:0] init_metric(input int unsigned st);
    return (st == 0) ? INIT_METRIC_ZERO : INIT_METRIC_MAX;
  endfunction

endpackage

// File: rtl/viterbi_addr_cnt.sv
// Loadable up/down address counter; tc_o flags MAX_VAL when counting up, zero when counting down.
module viterbi_addr_cnt
  import viterbi_pkg::*;
#(
  parameter int            AW      = 4,
  parameter logic [AW-1:0] MAX_VAL = '1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [AW-1:0] load_val_i,
  input  logic          en_i,
  input  logic          up_i,
  output logic [AW-1:0] cnt_o,
  output logic          tc_o
);

  logic [AW-1:0] count_q;
  logic [AW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i) begin
      count_d = up_i ? (count_q + AW'(1)) : (count_q - AW'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign cnt_o = count_q;
  assign tc_o  = up_i ? (count_q == MAX_VAL) : (count_q == '0);

endmodule

// File: rtl/viterbi_ctrl.sv
// Frame sequencer: feeds accepted pairs into BMC/ACS, addresses survivor writes, sweeps traceback.
module viterbi_ctrl
  import viterbi_pkg::*;
#(
  parameter int FRAME_LEN = 16,
  parameter int AW        = $clog2(FRAME_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    rx_pair,
  input  logic          frame_end,
  output logic [1:0]    bmc_rx_pair,
  output logic          acs_en,
  output logic          acs_init,
  output logic          sm_wr_en,
  output logic [AW-1:0] sm_wr_addr,
  output logic          tb_rd_en,
  output logic [AW-1:0] tb_rd_addr,
  output logic          tb_first,
  output logic          frame_done,
  output logic          busy,
  output logic [7:0]    frame_cnt
);

  state_e        state_q;
  logic [AW-1:0] last_addr_q;
  logic [AW-1:0] cnt;
  logic          cnt_tc;
  logic          cnt_load;
  logic [AW-1:0] cnt_load_val;
  logic          cnt_en;
  logic          cnt_up;
  logic          accept;

  assign in_ready = (state_q == IDLE) || (state_q == ACS);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != IDLE);

  // One counter serves as sym_cnt going up and the traceback address going down;
  // on the terminating pair it holds so it already points at last_addr for TB.
  always_comb begin
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_en       = 1'b0;
    cnt_up       = 1'b1;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_load     = 1'b1;
          cnt_load_val = frame_end ? '0 : AW'(1);
        end
      end
      ACS: begin
        if (accept && !(cnt_tc || frame_end)) cnt_en = 1'b1;
      end
      TB: begin
        cnt_up = 1'b0;
        cnt_en = !cnt_tc;
      end
      default: ;
    endcase
  end

  viterbi_addr_cnt #(
    .AW     (AW),
    .MAX_VAL(AW'(FRAME_LEN - 1))
  ) u_addr_cnt (
    .clk       (clk),
    .rst       (rst),
    .load_i    (cnt_load),
    .load_val_i(cnt_load_val),
    .en_i      (cnt_en),
    .up_i      (cnt_up),
    .cnt_o     (cnt),
    .tc_o      (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_addr_q <= '0;
      bmc_rx_pair <= '0;
      acs_en      <= 1'b0;
      acs_init    <= 1'b0;
      sm_wr_en    <= 1'b0;
      sm_wr_addr  <= '0;
      tb_rd_en    <= 1'b0;
      tb_rd_addr  <= '0;
      tb_first    <= 1'b0;
      frame_done  <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      acs_en     <= 1'b0;
      acs_init   <= 1'b0;
      sm_wr_en   <= 1'b0;
      tb_rd_en   <= 1'b0;
      tb_first   <= 1'b0;
      frame_done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            bmc_rx_pair <= rx_pair;
            acs_en      <= 1'b1;
            acs_init    <= 1'b1;
            sm_wr_en    <= 1'b1;
            sm_wr_addr  <= '0;
            last_addr_q <= '0;
            state_q     <= frame_end ? TB : ACS;
          end
        end
        ACS: begin
          if (accept) begin
            bmc_rx_pair <= rx_pair;
            acs_en      <= 1'b1;
            sm_wr_en    <= 1'b1;
            sm_wr_addr  <= cnt;
            if (cnt_tc || frame_end) begin
              last_addr_q <= cnt;
              state_q     <= TB;
            end
          end
        end
        // The read of last_addr lands one cycle after its write.
        TB: begin
          tb_rd_en   <= 1'b1;
          tb_rd_addr <= cnt;
          tb_first   <= (cnt == last_addr_q);
          if (cnt_tc) state_q <= DONE;
        end
        DONE: begin
          frame_done <= 1'b1;
          frame_cnt  <= frame_cnt + 8'd1;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_viterbi_ctrl.sv
// Directed self-checking bench for viterbi_ctrl with FRAME_LEN=16.
module tb_viterbi_ctrl;

  localparam int FL = 16;
  localparam int AW = $clog2(FL);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    rx_pair;
  logic          frame_end;
  logic [1:0]    bmc_rx_pair;
  logic          acs_en;
  logic          acs_init;
  logic          sm_wr_en;
  logic [AW-1:0] sm_wr_addr;
  logic          tb_rd_en;
  logic [AW-1:0] tb_rd_addr;
  logic          tb_first;
  logic          frame_done;
  logic          busy;
  logic [7:0]    frame_cnt;

  int checks = 0;
  int errors = 0;
  logic [7:0] expFrameCnt = 8'd0;

  viterbi_ctrl #(.FRAME_LEN(FL)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .rx_pair    (rx_pair),
    .frame_end  (frame_end),
    .bmc_rx_pair(bmc_rx_pair),
    .acs_en     (acs_en),
    .acs_init   (acs_init),
    .sm_wr_en   (sm_wr_en),
    .sm_wr_addr (sm_wr_addr),
    .tb_rd_en   (tb_rd_en),
    .tb_rd_addr (tb_rd_addr),
    .tb_first   (tb_first),
    .frame_done (frame_done),
    .busy       (busy),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] p, input logic fe);
    in_valid  = v;
    rx_pair   = p;
    frame_end = fe;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkResetState();
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_acs_en", 32'(acs_en), 32'd0);
    checkOutput("rst_acs_init", 32'(acs_init), 32'd0);
    checkOutput("rst_sm_wr_en", 32'(sm_wr_en), 32'd0);
    checkOutput("rst_sm_wr_addr", 32'(sm_wr_addr), 32'd0);
    checkOutput("rst_bmc", 32'(bmc_rx_pair), 32'd0);
    checkOutput("rst_tb_rd_en", 32'(tb_rd_en), 32'd0);
    checkOutput("rst_tb_rd_addr", 32'(tb_rd_addr), 32'd0);
    checkOutput("rst_tb_first", 32'(tb_first), 32'd0);
    checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_frame_cnt", 32'(frame_cnt), 32'd0);
  endtask

  // One accepted pair; its datapath outputs are visible in the following cycle.
  task automatic sendPair(input int idx, input logic [1:0] p, input logic fe);
    logic lastOne;
    lastOne = fe || (idx == FL - 1);
    applyStimulus(1'b1, p, fe);
    tick();
    checkOutput("acs_en", 32'(acs_en), 32'd1);
    checkOutput("sm_wr_en", 32'(sm_wr_en), 32'd1);
    checkOutput("sm_wr_addr", 32'(sm_wr_addr), 32'(idx));
    checkOutput("acs_init", 32'(acs_init), 32'(idx == 0));
    checkOutput("bmc_rx_pair", 32'(bmc_rx_pair), 32'(p));
    checkOutput("in_ready_acs", 32'(in_ready), 32'(!lastOne));
    checkOutput("busy_acs", 32'(busy), 32'd1);
    checkOutput("tb_rd_en_acs", 32'(tb_rd_en), 32'd0);
    checkOutput("frame_done_acs", 32'(frame_done), 32'd0);
  endtask

  // Traceback sweep from last down to 0, then the frame_done pulse; in_valid is held
  // high with frame_end to show it is ignored while in_ready is low.
  task automatic runTraceback(input int last);
    applyStimulus(1'b1, 2'b11, 1'b1);
    for (int j = 0; j <= last; j++) begin
      tick();
      checkOutput("tb_rd_en", 32'(tb_rd_en), 32'd1);
      checkOutput("tb_rd_addr", 32'(tb_rd_addr), 32'(last - j));
      checkOutput("tb_first", 32'(tb_first), 32'(j == 0));
      checkOutput("acs_en_tb", 32'(acs_en), 32'd0);
      checkOutput("sm_wr_en_tb", 32'(sm_wr_en), 32'd0);
      checkOutput("in_ready_tb", 32'(in_ready), 32'd0);
      checkOutput("busy_tb", 32'(busy), 32'd1);
      checkOutput("frame_done_tb", 32'(frame_done), 32'd0);
    end
    tick();
    expFrameCnt = expFrameCnt + 8'd1;
    checkOutput("frame_done", 32'(frame_done), 32'd1);
    checkOutput("frame_cnt", 32'(frame_cnt), 32'(expFrameCnt));
    checkOutput("in_ready_done", 32'(in_ready), 32'd1);
    checkOutput("busy_idle", 32'(busy), 32'd0);
    checkOutput("tb_rd_en_done", 32'(tb_rd_en), 32'd0);
    applyStimulus(1'b0, 2'b00, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 2'b00, 1'b0);
    tick();
    checkResetState();
    tick();
    rst = 1'b0;
    tick();
    checkOutput("idle_in_ready", 32'(in_ready), 32'd1);
    checkOutput("idle_busy", 32'(busy), 32'd0);

    $display("[TB] full frame");
    for (int i = 0; i < FL; i++) sendPair(i, 2'((i * 3 + 1) % 4), 1'b0);
    runTraceback(FL - 1);
    tick();
    checkOutput("frame_done_pulse", 32'(frame_done), 32'd0);

    $display("[TB] short frame");
    for (int i = 0; i < 5; i++) sendPair(i, 2'(i), i == 4);
    runTraceback(4);

    $display("[TB] stalls");
    for (int i = 0; i < 8; i++) sendPair(i, 2'((i + 2) % 4), 1'b0);
    for (int s = 0; s < 3; s++) begin
      applyStimulus(1'b0, 2'b00, 1'b1);
      tick();
      checkOutput("stall_acs_en", 32'(acs_en), 32'd0);
      checkOutput("stall_sm_wr_en", 32'(sm_wr_en), 32'd0);
      checkOutput("stall_bmc_hold", 32'(bmc_rx_pair), 32'd1);
      checkOutput("stall_in_ready", 32'(in_ready), 32'd1);
      checkOutput("stall_busy", 32'(busy), 32'd1);
    end
    for (int i = 8; i < FL; i++) sendPair(i, 2'((i + 2) % 4), 1'b0);
    runTraceback(FL - 1);

    $display("[TB] reset mid-frame");
    for (int i = 0; i < 9; i++) sendPair(i, 2'(3 - (i % 4)), 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expFrameCnt = 8'd0;
    checkResetState();
    for (int s = 0; s < 3; s++) begin
      tick();
      checkOutput("abandon_frame_done", 32'(frame_done), 32'd0);
      checkOutput("abandon_frame_cnt", 32'(frame_cnt), 32'(expFrameCnt));
      checkOutput("abandon_busy", 32'(busy), 32'd0);
    end
    for (int i = 0; i < 3; i++) sendPair(i, 2'(i + 1), i == 2);
    runTraceback(2);

    $display("[TB] single-pair frame");
    sendPair(0, 2'b10, 1'b1);
    runTraceback(0);

    $display("[TB] frame counter wrap");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expFrameCnt = 8'd0;
    checkResetState();
    for (int f = 0; f < 256; f++) begin
      sendPair(0, 2'(f % 4), 1'b1);
      runTraceback(0);
    end
    checkOutput("wrap_frame_cnt", 32'(frame_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
